// File: rtl/dmem_loader_pkg.sv
// Shared types and constants for the data-memory loader: FSM states,
// frame-byte positions and default geometry.
package dmem_loader_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned LEN_W               = 16;
  localparam int unsigned LANES               = WORD_W / BYTE_W;
  localparam int unsigned LANE_W              = 2;

  // Byte positions within a frame; data occupies POS_DATA .. POS_DATA+4N-1,
  // and the checksum byte follows immediately after the data.
  localparam int unsigned POS_LEN_LO = 0;
  localparam int unsigned POS_LEN_HI = 1;
  localparam int unsigned POS_DATA   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_COLLECT,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer: each shifted byte enters at the top lane,
// so after four shifts the first byte sits in [7:0].
module word_packer
  import dmem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_c
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clr_i) begin
      lane_d = '0;
      word_d = '0;
    end else if (shift_i) begin
      lane_d = lane_q + LANE_W'(1);
      word_d = {byte_i, word_q[WORD_W-1:BYTE_W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  // High in the cycle the last lane of a word is being shifted in.
  assign full_c = shift_i && (lane_q == LANE_W'(LANES - 1));
  assign word_o = word_q;

endmodule

// File: rtl/dmem_loader.sv
// Frame-driven data-memory loader: length, packed words, XOR checksum.
// Holds the core in reset until a frame completes with a good checksum.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d, we_q, we_d, hold_q, hold_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic              accept_c, pack_clr_c, pack_shift_c, word_full_c;
  logic [LEN_W-1:0]  len_c;
  logic              len_ok_c, last_word_c;

  assign accept_c    = byte_valid && ready_q;
  assign len_c       = {byte_in, len_lo_q};
  assign len_ok_c    = (len_c != '0) && (32'(len_c) <= DEPTH_WORDS);
  assign last_word_c = ((idx_q + LEN_W'(1)) == len_q);

  word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pack_clr_c),
    .shift_i (pack_shift_c),
    .byte_i  (byte_in),
    .word_o  (mem_wdata),
    .full_c  (word_full_c)
  );

  // Next state, datapath updates, and state-decoded outputs for the next cycle.
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    idx_d        = idx_q;
    xor_d        = xor_q;
    addr_d       = addr_q;
    pack_clr_c   = 1'b0;
    pack_shift_c = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN0;
          xor_d      = '0;
          idx_d      = '0;
          addr_d     = '0;
          pack_clr_c = 1'b1;
        end
      end
      ST_LEN0: begin
        if (accept_c) begin
          len_lo_d = byte_in;
          xor_d    = xor_q ^ byte_in;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept_c) begin
          len_d   = len_c;
          xor_d   = xor_q ^ byte_in;
          state_d = len_ok_c ? ST_COLLECT : ST_ERR;
        end
      end
      ST_COLLECT: begin
        if (accept_c) begin
          xor_d        = xor_q ^ byte_in;
          pack_shift_c = 1'b1;
          if (word_full_c) begin
            state_d = ST_WRITE;
            addr_d  = ADDR_W'({idx_q, 2'b00});
          end
        end
      end
      ST_WRITE: begin
        if (last_word_c) begin
          state_d = ST_CHK;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_CHK: begin
        if (accept_c) begin
          state_d = (xor_q == byte_in) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
              (state_d == ST_COLLECT) || (state_d == ST_CHK);
    busy_d  = ready_d || (state_d == ST_WRITE);
    we_d    = (state_d == ST_WRITE);
    hold_d  = (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      xor_q    <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      hold_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign byte_ready   = ready_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign cpu_rst_hold = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: frames are built from a byte-level
// reference model and the observed memory writes are compared to it.
module tb_dmem_loader;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_hold;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];

  dmem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst_hold (cpu_rst_hold),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Record every memory write; no byte may be accepted while writing.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq.push_back('{mem_addr, mem_wdata});
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_ready: byte_ready=%b during write, want 0", byte_ready);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; presents a byte and returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %02h not accepted, byte_ready=%b want 1", b, byte_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: random words, 1: word k = k*0x01010101, 2: every word = fixed
  task automatic run_frame(input string name, input int n, input int mode,
                           input logic [31:0] fixed, input bit bad_chk,
                           input bit stall, input bit start_mid);
    logic [7:0]  fb[$];
    logic [31:0] exp_w[$];
    logic [31:0] w;
    logic [7:0]  chk = 8'h00;
    fb.push_back(8'(n));
    fb.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = (mode == 0) ? $urandom : (mode == 1) ? 32'(k) * 32'h01010101 : fixed;
      exp_w.push_back(w);
      for (int l = 0; l < 4; l++) fb.push_back(8'((w >> (8 * l)) & 32'hFF));
    end
    foreach (fb[i]) chk = chk ^ fb[i];
    fb.push_back(bad_chk ? ((chk == 8'h00) ? 8'hFF : 8'h00) : chk);

    wq.delete();
    pulse_start();
    checks++;
    if (byte_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_started: ready=%b busy=%b done=%b err=%b want 1 1 0 0",
               name, byte_ready, busy, done, err);
    end

    foreach (fb[i]) begin
      if (stall && (i % 2 == 0)) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        start      = start_mid && (i == 6);
        @(negedge clk);
        start      = 1'b0;
      end
      send_byte(fb[i]);
    end
    byte_valid = 1'b0;

    checks++;
    if (wq.size() != n) begin
      errors++;
      $display("FAIL %s_wcount: writes=%0d want %0d", name, wq.size(), n);
    end
    for (int k = 0; k < n && k < wq.size(); k++) begin
      checks++;
      if (wq[k].a !== 32'(k * 4) || wq[k].d !== exp_w[k]) begin
        errors++;
        $display("FAIL %s_write%0d: addr=%h data=%h want addr=%h data=%h",
                 name, k, wq[k].a, wq[k].d, 32'(k * 4), exp_w[k]);
      end
    end
    checks++;
    if (done !== !bad_chk || err !== bad_chk || cpu_rst_hold !== bad_chk ||
        busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: done=%b err=%b hold=%b busy=%b ready=%b want %b %b %b 0 0",
               name, done, err, cpu_rst_hold, busy, byte_ready, !bad_chk, bad_chk, bad_chk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_rst_hold !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: ready=%b we=%b addr=%h data=%h busy=%b done=%b err=%b hold=%b",
               byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_rst_hold);
    end
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0 || cpu_rst_hold !== 1'b1) begin
      errors++;
      $display("FAIL idle_ignores_bytes: ready=%b busy=%b hold=%b want 0 0 1",
               byte_ready, busy, cpu_rst_hold);
    end
  endtask

  task automatic test_len_error(input int n);
    wq.delete();
    pulse_start();
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    byte_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst_hold !== 1'b1 || busy !== 1'b0 ||
        byte_ready !== 1'b0 || wq.size() != 0) begin
      errors++;
      $display("FAIL len_error_%0d: err=%b done=%b hold=%b busy=%b ready=%b writes=%0d want 1 0 1 0 0 0",
               n, err, done, cpu_rst_hold, busy, byte_ready, wq.size());
    end
  endtask

  task automatic test_single_word();
    run_frame("single", 1, 2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    run_frame("badchk", 1, 2, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_full_depth();
    run_frame("full", DEPTH, 1, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_ignore();
    run_frame("stall", 3, 0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 4; t++) begin
      run_frame("rand", int'($urandom_range(1, 6)), 0, 32'h0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_load();
    wq.delete();
    pulse_start();
    send_byte(8'd3);
    send_byte(8'd0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    byte_in    = 8'hA5;
    byte_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_rst_hold !== 1'b1) begin
      errors++;
      $display("FAIL midreset_values: ready=%b we=%b addr=%h data=%h busy=%b done=%b err=%b hold=%b",
               byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_rst_hold);
    end
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL midreset_writes: writes=%0d want 2", wq.size());
    end
    @(negedge clk);
    rst        = 1'b0;
    byte_valid = 1'b0;
    run_frame("reload", 2, 0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_len_error(0);
    test_len_error(257);
    test_single_word();
    test_bad_checksum();
    test_full_depth();
    test_stall_ignore();
    test_random_frames();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
# dmem_loader

Hardware writer for the processor's data memory: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words and writes them to data memory at consecutive word addresses from 0. It holds the core in reset while loading, so a program starts on pre-initialised data. It sits between the host/byte-stream source and the data-memory write port, muxed in ahead of the core's store path.

## Interface
- DEPTH_WORDS, 256: data-memory depth in words; legal word count is 1..DEPTH_WORDS.
- ADDR_W, 32: byte-address width of the data-memory port.
- clk  in  1: single clock; all state changes on rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  in  8: stream byte.
- byte_valid  in  1: byte_in is valid.
- byte_ready  out  1: loader can accept a byte this cycle.
- mem_we  out  1: one-cycle data-memory write strobe.
- mem_addr  out  ADDR_W: byte address, always a multiple of 4.
- mem_wdata  out  32: packed word.
- cpu_rst_hold  out  1: hold the core in reset.
- busy  out  1: a load is in progress.
- done  out  1: last load completed with a good checksum; sticky until next start.
- err  out  1: length out of range or checksum mismatch; sticky until next start.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4·N data bytes, CHK. CHK is the XOR of all preceding frame bytes, including the length bytes.
- States:
  - IDLE -> LEN0 on start.
  - LEN0 -> LEN1 on byte accept.
  - LEN1 -> COLLECT if 1 ≤ N ≤ DEPTH_WORDS; otherwise -> ERR.
  - COLLECT -> WRITE after the 4th byte of a word.
  - WRITE -> COLLECT if words remain; otherwise -> CHK.
  - CHK -> DONE if the running XOR equals the received byte; otherwise -> ERR.
  - DONE or ERR -> LEN0 on start.
- A byte is accepted when byte_valid && byte_ready.
- byte_ready = 1 in LEN0, LEN1, COLLECT and CHK; 0 elsewhere.
- Packing: the 1st byte of a word goes to [7:0] and the 4th byte to [31:24].
- mem_wdata/mem_addr are registered and stable during WRITE; mem_we = 1 only in WRITE.
- Word index counter runs 0..N-1; mem_addr = index·4 (zero-extended to ADDR_W). The counter never wraps because N is range-checked first.
- cpu_rst_hold is 1 in every state except DONE. ERR keeps the core held.
- busy = 1 in LEN0, LEN1, COLLECT, WRITE and CHK.
- start while busy is ignored.
- byte_valid outside an accepting state is ignored, and no byte is consumed.

## Timing
- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0, cpu_rst_hold 1.
- Reset mid-load: all outputs return to reset values asynchronously; a partial word is discarded, and words already written stay in memory.
- start is registered: byte_ready rises the cycle after start.
- Per word: 4 accept cycles (minimum) plus 1 WRITE cycle with byte_ready = 0. Minimum frame time is 1 + 2 + 5N + 1 cycles from start to DONE.
- The write occurs in the cycle after the 4th byte is accepted.
- done/err assert in the cycle after the CHK byte is accepted (or after LEN_HI for a length error). cpu_rst_hold falls in that same cycle.
- The source may deassert byte_valid at any point; the loader waits indefinitely, with no timeout.
- start arriving in DONE or ERR clears done/err on the next edge.

## Structure
- Package dmem_loader_pkg holds:
  - the state enum (IDLE, LEN0, LEN1, COLLECT, WRITE, CHK, DONE, ERR);
  - the frame-byte position constants;
  - the default depth constant.
- Sub-module word_packer: byte-lane shift register plus 2-bit lane counter, with a "word full" output and a clear input. The FSM, word counter and XOR accumulator stay in the top.

## Test plan
- Length error: N=0 or N=257 -> err=1 after LEN_HI, no mem_we, cpu_rst_hold stays 1.
- Good single word: start, then bytes 01 00 EF BE AD DE, CHK = 01^EF^BE^AD^DE = 0x23 -> one write of addr 0, data 0xDEADBEEF. done=1, cpu_rst_hold=0.
- Full-depth load: N=256, word k = k·0x01010101 -> 256 writes, last at addr 1020 with data 0xFFFFFFFF. No wrap; done=1.
- Bad checksum: same frame as the good single word with CHK=0x00 -> the word is still written, then err=1, done=0, cpu_rst_hold=1.
- Stall and ignore: byte_valid toggled every other cycle and start pulsed mid-load -> data unchanged and load unaffected. Bytes are never accepted in the WRITE cycles.
- Reset at the 3rd data byte of word 2 -> all outputs return to reset values immediately. A fresh start then reloads from addr 0.
